// File: rtl/lane_unpacker_if.sv
// Stream bundle for lane_unpacker: packed-word input side and per-lane output side.
// The slave modport is the unpacker; the master modport is whatever feeds and drains it.
interface lane_unpacker_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_lmode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, in_lmode, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_lmode, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/lane_unpacker.sv
// Splits a packed 32-bit adder result into one 32-bit lane or two extended 16-bit lanes,
// emitting lanes on a valid/ready stream and counting every delivered lane.
module lane_unpacker #(
    parameter bit SIGN_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    lane_unpacker_if.slave  bus,
    output logic [15:0]     lane_cnt
);

    typedef enum logic [1:0] {StIdle, StEmitFull, StEmitLo, StEmitHi} state_e;

    state_e      state_q, state_d;
    logic [31:0] word_q;
    logic        lmode_q;
    logic [15:0] lane_cnt_q;
    logic        accept;
    logic        deliver;

    function automatic logic [31:0] ext(input logic [15:0] x);
        return SIGN_EXT ? {{16{x[15]}}, x} : {16'h0000, x};
    endfunction

    assign accept   = bus.in_valid && bus.in_ready;
    assign deliver  = bus.out_valid && bus.out_ready;
    assign lane_cnt = lane_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= 32'h0;
            lmode_q    <= 1'b0;
            lane_cnt_q <= 16'h0;
        end else begin
            if (accept) begin
                word_q  <= bus.in_data;
                lmode_q <= bus.in_lmode;
            end
            if (deliver) begin
                lane_cnt_q <= lane_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) state_d = bus.in_lmode ? StEmitLo : StEmitFull;
            end
            StEmitLo: begin
                if (bus.out_ready) state_d = StEmitHi;
            end
            StEmitFull, StEmitHi: begin
                // Final lane leaving; a word accepted on the same edge starts without a bubble.
                if (bus.out_ready) begin
                    if (accept) state_d = bus.in_lmode ? StEmitLo : StEmitFull;
                    else        state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 32'h0;
        case (state_q)
            StIdle: begin
                bus.in_ready = !rst;
            end
            StEmitFull: begin
                bus.out_valid = 1'b1;
                bus.out_data  = word_q;
                bus.in_ready  = !rst && bus.out_ready;
            end
            StEmitLo: begin
                bus.out_valid = 1'b1;
                bus.out_data  = ext(word_q[15:0]);
            end
            StEmitHi: begin
                bus.out_valid = 1'b1;
                bus.out_data  = ext(word_q[31:16]);
                bus.in_ready  = !rst && bus.out_ready;
            end
            default: ;
        endcase
        // In 16-bit mode only the high lane closes the word.
        bus.out_last = bus.out_valid && (!lmode_q || state_q == StEmitHi);
    end

endmodule

// File: tb/tb_lane_unpacker.sv
// Bench for lane_unpacker: a lane-queue model checks both extension variants every cycle,
// and directed sequences pin the model with hand-computed values.
module tb_lane_unpacker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_lmode;
    logic        out_ready;
    logic [15:0] cnt_sx;
    logic [15:0] cnt_zx;

    int checks   = 0;
    int failures = 0;

    lane_unpacker_if if_sx ();
    lane_unpacker_if if_zx ();

    assign if_sx.in_valid  = in_valid;
    assign if_sx.in_data   = in_data;
    assign if_sx.in_lmode  = in_lmode;
    assign if_sx.out_ready = out_ready;
    assign if_zx.in_valid  = in_valid;
    assign if_zx.in_data   = in_data;
    assign if_zx.in_lmode  = in_lmode;
    assign if_zx.out_ready = out_ready;

    lane_unpacker #(.SIGN_EXT(1'b1)) dut_sx (
        .clk      (clk),
        .rst      (rst),
        .bus      (if_sx),
        .lane_cnt (cnt_sx)
    );

    lane_unpacker #(.SIGN_EXT(1'b0)) dut_zx (
        .clk      (clk),
        .rst      (rst),
        .bus      (if_zx),
        .lane_cnt (cnt_zx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of lanes still owed to the consumer, plus the delivered-lane count.
    typedef struct {
        logic [31:0] d_sx;
        logic [31:0] d_zx;
        bit          last;
    } lane_t;

    lane_t       q[$];
    logic [15:0] mdl_cnt = 16'h0;
    bit          was_rst = 1'b1;
    bit          exp_ready;
    bit          m_acc;
    bit          m_del;

    function automatic lane_t mk(input logic [15:0] x, input logic [31:0] full,
                                 input bit half, input bit last);
        lane_t l;
        l.d_sx = half ? {{16{x[15]}}, x} : full;
        l.d_zx = half ? {16'h0000, x} : full;
        l.last = last;
        return l;
    endfunction

    always @(negedge clk) begin
        exp_ready = !rst && (q.size() == 0 || (q.size() == 1 && out_ready));
        check("in_ready_sx", 32'(if_sx.in_ready), 32'(exp_ready));
        check("in_ready_zx", 32'(if_zx.in_ready), 32'(exp_ready));
        check("out_valid_sx", 32'(if_sx.out_valid), 32'(q.size() != 0));
        check("out_valid_zx", 32'(if_zx.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_data_sx", if_sx.out_data, q[0].d_sx);
            check("out_data_zx", if_zx.out_data, q[0].d_zx);
            check("out_last_sx", 32'(if_sx.out_last), 32'(q[0].last));
            check("out_last_zx", 32'(if_zx.out_last), 32'(q[0].last));
        end else if (was_rst) begin
            check("rst_data", if_sx.out_data, 32'h0);
            check("rst_last", 32'(if_sx.out_last), 32'h0);
        end
        check("lane_cnt_sx", 32'(cnt_sx), 32'(mdl_cnt));
        check("lane_cnt_zx", 32'(cnt_zx), 32'(mdl_cnt));

        // Advance the model to what must hold after the coming rising edge.
        was_rst = rst;
        if (rst) begin
            q.delete();
            mdl_cnt = 16'h0;
        end else begin
            m_del = out_ready && q.size() != 0;
            m_acc = in_valid && exp_ready;
            if (m_del) begin
                void'(q.pop_front());
                mdl_cnt = mdl_cnt + 16'd1;
            end
            if (m_acc) begin
                if (in_lmode) begin
                    q.push_back(mk(in_data[15:0], in_data, 1'b1, 1'b0));
                    q.push_back(mk(in_data[31:16], in_data, 1'b1, 1'b1));
                end else begin
                    q.push_back(mk(16'h0, in_data, 1'b0, 1'b1));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] words[4];
    logic        modes[4];
    logic [5:0]  lasts;
    int          n;
    int          idx;
    bit          started;
    bit          bubble;
    bit          acc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hCAFE_F00D;
        in_lmode  = 1'b0;
        out_ready = 1'b1;

        // Reset with a handshake attempt that must be ignored.
        repeat (2) begin
            @(negedge clk);
            check("reset_in_ready", 32'(if_sx.in_ready), 32'h0);
            check("reset_out_valid", 32'(if_sx.out_valid), 32'h0);
            check("reset_out_data", if_sx.out_data, 32'h0);
            check("reset_lane_cnt", 32'(cnt_sx), 32'h0);
            tick();
        end

        // 32-bit lane, one-cycle latency.
        rst      = 1'b0;
        in_data  = 32'h8000_0001;
        in_lmode = 1'b0;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("full_data", if_sx.out_data, 32'h8000_0001);
        check("full_last", 32'(if_sx.out_last), 32'h1);
        check("full_cnt_before", 32'(cnt_sx), 32'h0);
        tick();
        @(negedge clk);
        check("full_cnt_after", 32'(cnt_sx), 32'h1);
        check("full_idle", 32'(if_sx.out_valid), 32'h0);
        tick();

        // Two 16-bit lanes, both extension modes.
        in_valid = 1'b1;
        in_data  = 32'h7FFF_8001;
        in_lmode = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("lo_sx", if_sx.out_data, 32'hFFFF_8001);
        check("lo_zx", if_zx.out_data, 32'h0000_8001);
        check("lo_last", 32'(if_sx.out_last), 32'h0);
        tick();
        @(negedge clk);
        check("hi_sx", if_sx.out_data, 32'h0000_7FFF);
        check("hi_zx", if_zx.out_data, 32'h0000_7FFF);
        check("hi_last", 32'(if_sx.out_last), 32'h1);
        tick();

        // Backpressure in the low lane; a stray word offered meanwhile must be refused.
        in_valid = 1'b1;
        in_data  = 32'h1357_9BDF;
        in_lmode = 1'b1;
        tick();
        in_data   = 32'hDEAD_BEEF;
        in_lmode  = 1'b0;
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 32'(if_sx.in_ready), 32'h0);
            check("stall_data", if_sx.out_data, 32'hFFFF_9BDF);
            check("stall_last", 32'(if_sx.out_last), 32'h0);
            check("stall_cnt", 32'(cnt_sx), 32'h3);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_lo", if_sx.out_data, 32'hFFFF_9BDF);
        tick();
        @(negedge clk);
        check("release_hi", if_sx.out_data, 32'h0000_1357);
        check("release_hi_last", 32'(if_sx.out_last), 32'h1);
        tick();
        @(negedge clk);
        check("release_cnt", 32'(cnt_sx), 32'h5);
        tick();

        // Back-to-back words, alternating lane mode.
        words[0] = 32'hA000_0001; modes[0] = 1'b0;
        words[1] = 32'h8002_0003; modes[1] = 1'b1;
        words[2] = 32'h0000_0004; modes[2] = 1'b0;
        words[3] = 32'h0005_FFFE; modes[3] = 1'b1;
        idx = 0; n = 0; started = 1'b0; bubble = 1'b0; lasts = 6'h0;
        in_valid = 1'b1;
        in_data  = words[0];
        in_lmode = modes[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if_sx.out_valid) begin
                if (n < 6) lasts[n] = if_sx.out_last;
                n++;
                started = 1'b1;
            end else if (started && n < 6) begin
                bubble = 1'b1;
            end
            acc = in_valid && if_sx.in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    in_data  = words[idx];
                    in_lmode = modes[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_lanes", 32'(n), 32'd6);
        check("b2b_bubble", 32'(bubble), 32'h0);
        check("b2b_last_pattern", 32'(lasts), 32'(6'b101101));
        @(negedge clk);
        check("b2b_cnt", 32'(cnt_sx), 32'd11);
        tick();

        // Counter wrap: bring the count to FFFF, then one more lane.
        in_valid  = 1'b1;
        in_lmode  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 65535 - 11; i++) begin
            in_data = 32'(i);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("wrap_cnt_fffe", 32'(cnt_sx), 32'h0000_FFFE);
        tick();
        @(negedge clk);
        check("wrap_cnt_ffff", 32'(cnt_sx), 32'h0000_FFFF);
        tick();
        in_valid = 1'b1;
        in_data  = 32'h0000_0042;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("wrap_cnt_hold", 32'(cnt_sx), 32'h0000_FFFF);
        tick();
        @(negedge clk);
        check("wrap_cnt_zero", 32'(cnt_sx), 32'h0);
        tick();

        // Reset while the low lane is showing; the high lane must never appear.
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        in_lmode = 1'b1;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("midrst_lo", if_sx.out_data, 32'h0000_5678);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(if_sx.out_valid), 32'h0);
        check("midrst_cnt", 32'(cnt_sx), 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            check("midrst_no_hi", 32'(if_sx.out_valid), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
